// File: rtl/coef_gather_if.sv
// Serial coefficient stream in, packed wide word out.
// Both handshakes share one bundle; the DUT side is the slave modport.
interface coef_gather_if #(
  parameter int DATA = 32,
  parameter int PACK = 4,
  parameter int CW   = $clog2(PACK + 1)
) ();
  logic [DATA-1:0]      in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [DATA*PACK-1:0] out_data;
  logic [CW-1:0]        out_count;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_count, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_count, out_last, out_valid
  );
endinterface

// File: rtl/coef_gather.sv
// Gathers consecutive DATA-bit coefficients into one PACK-lane word; in_last
// closes a group early and flushes a zero-padded partial word.
module coef_gather #(
  parameter int DATA = 32,
  parameter int PACK = 4,
  parameter int CW   = $clog2(PACK + 1)
) (
  input  logic         clk,
  input  logic         reset,
  coef_gather_if.slave bus
);

  typedef enum logic {
    S_FILLING = 1'b0,
    S_DONE    = 1'b1
  } acc_state_t;

  acc_state_t                 state_q, state_d;
  logic [PACK-1:0][DATA-1:0]  acc_data_q, acc_data_d;
  logic [CW-1:0]              acc_cnt_q, acc_cnt_d;
  logic                       acc_last_q, acc_last_d;

  logic [PACK-1:0][DATA-1:0]  out_data_q, out_data_d;
  logic [CW-1:0]              out_count_q, out_count_d;
  logic                       out_last_q, out_last_d;
  logic                       out_valid_q, out_valid_d;

  logic                       acc_done;
  logic                       accept;
  logic                       xfer;
  logic [CW-1:0]              cnt_inc;
  logic                       closes;

  assign acc_done = (state_q == S_DONE);
  assign accept   = bus.in_valid && !acc_done;
  // A closed group moves out as soon as the output slot is free or draining.
  assign xfer     = acc_done && (!out_valid_q || bus.out_ready);
  assign cnt_inc  = acc_cnt_q + CW'(1);
  assign closes   = (cnt_inc == CW'(PACK)) || bus.in_last;

  // Lanes clear on transfer, so lanes beyond a partial count read as zero.
  generate
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
      assign acc_data_d[gi] = xfer ? '0 :
                              (accept && (acc_cnt_q == CW'(gi))) ? bus.in_data :
                              acc_data_q[gi];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    acc_last_d  = acc_last_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (xfer) begin
      state_d     = S_FILLING;
      acc_cnt_d   = '0;
      acc_last_d  = 1'b0;
      out_data_d  = acc_data_q;
      out_count_d = acc_cnt_q;
      out_last_d  = acc_last_q;
      out_valid_d = 1'b1;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        acc_cnt_d = cnt_inc;
        if (closes) begin
          state_d    = S_DONE;
          acc_last_d = bus.in_last;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FILLING;
      acc_data_q  <= '0;
      acc_cnt_q   <= '0;
      acc_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_data_q  <= acc_data_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_last_q  <= acc_last_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = !acc_done;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_coef_gather.sv
// Self-checking bench for coef_gather: directed vector table, hand-written
// backpressure/reset sequences, and a randomized run against a grouping model.
module tb_coef_gather;
  localparam int DATA = 32;
  localparam int PACK = 4;
  localparam int CW   = $clog2(PACK + 1);
  localparam int W    = DATA * PACK;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coef_gather_if #(.DATA(DATA), .PACK(PACK), .CW(CW)) bus ();

  coef_gather #(.DATA(DATA), .PACK(PACK), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input int l0, input int l1, input int l2, input int l3);
    logic [W-1:0] r;
    r = {l3[DATA-1:0], l2[DATA-1:0], l1[DATA-1:0], l0[DATA-1:0]};
    return r;
  endfunction

  typedef struct {
    bit           v;
    bit           l;
    int           d;
    bit           exp_ir;
    bit           exp_ov;
    logic [W-1:0] exp_data;
    int           exp_cnt;
    bit           exp_last;
  } vec_t;

  function automatic vec_t mk(bit v, bit l, int d, bit ir, bit ov,
                              logic [W-1:0] ed, int ec, bit el);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.exp_ir = ir; r.exp_ov = ov;
    r.exp_data = ed; r.exp_cnt = ec; r.exp_last = el;
    return r;
  endfunction

  typedef struct {
    logic [W-1:0] d;
    int           c;
    bit           l;
  } orec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  vec_t  vecs[19];
  orec_t exp_q[$];

  initial begin
    vecs[0]  = mk(1, 0, 1,  1, 0, '0, 0, 0);
    vecs[1]  = mk(1, 0, 2,  1, 0, '0, 0, 0);
    vecs[2]  = mk(1, 0, 3,  1, 0, '0, 0, 0);
    vecs[3]  = mk(1, 0, 4,  1, 0, '0, 0, 0);
    vecs[4]  = mk(1, 0, 5,  0, 1, pk(1, 2, 3, 4), 4, 0);
    vecs[5]  = mk(1, 0, 5,  1, 0, '0, 0, 0);
    vecs[6]  = mk(1, 1, 6,  1, 0, '0, 0, 0);
    vecs[7]  = mk(1, 0, 7,  0, 1, pk(5, 6, 0, 0), 2, 1);
    vecs[8]  = mk(1, 0, 7,  1, 0, '0, 0, 0);
    vecs[9]  = mk(1, 0, 8,  1, 0, '0, 0, 0);
    vecs[10] = mk(1, 0, 9,  1, 0, '0, 0, 0);
    vecs[11] = mk(1, 1, 10, 1, 0, '0, 0, 0);
    vecs[12] = mk(0, 0, 0,  0, 1, pk(7, 8, 9, 10), 4, 1);
    vecs[13] = mk(1, 0, 11, 1, 0, '0, 0, 0);
    vecs[14] = mk(1, 0, 12, 1, 0, '0, 0, 0);
    vecs[15] = mk(1, 0, 13, 1, 0, '0, 0, 0);
    vecs[16] = mk(1, 0, 14, 1, 0, '0, 0, 0);
    vecs[17] = mk(0, 0, 0,  0, 1, pk(11, 12, 13, 14), 4, 0);
    vecs[18] = mk(0, 0, 0,  1, 0, '0, 0, 0);

    // Reset state
    do_reset();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_last",  bus.out_last,  0);
    chk("rst_in_ready",  bus.in_ready,  1);

    // Directed table: full group, flushed partial, in_last on a full group
    for (int i = 0; i < 19; i++) begin
      bus.in_valid = vecs[i].v;
      bus.in_last  = vecs[i].l;
      bus.in_data  = vecs[i].d;
      chk($sformatf("vec%0d_in_ready", i), bus.in_ready, vecs[i].exp_ir);
      tick();
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, vecs[i].exp_ov);
      if (vecs[i].exp_ov) begin
        chk($sformatf("vec%0d_out_data", i),  bus.out_data,  vecs[i].exp_data);
        chk($sformatf("vec%0d_out_count", i), bus.out_count, vecs[i].exp_cnt);
        chk($sformatf("vec%0d_out_last", i),  bus.out_last,  vecs[i].exp_last);
      end
    end
    idle();

    // Backpressure: 8 words back-to-back with the output stalled
    begin
      int  w = 1;
      int  guard = 0;
      bit  acc;
      do_reset();
      bus.out_ready = 1'b0;
      while (w <= 8 && guard < 100) begin
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        bus.in_data  = w;
        acc = bus.in_ready;
        tick();
        if (acc) w++;
        guard++;
        if (bus.out_valid) chk("bp_first_stable", bus.out_data, pk(1, 2, 3, 4));
      end
      chk("bp_words_sent", w, 9);
      idle();
      for (int k = 0; k < 3; k++) begin
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_out_valid_held", bus.out_valid, 1);
        chk("bp_out_data_held", bus.out_data, pk(1, 2, 3, 4));
        chk("bp_out_count_held", bus.out_count, 4);
        tick();
      end
      bus.out_ready = 1'b1;
      tick();
      chk("bp_second_valid", bus.out_valid, 1);
      chk("bp_second_data", bus.out_data, pk(5, 6, 7, 8));
      chk("bp_second_count", bus.out_count, 4);
      chk("bp_in_ready_back", bus.in_ready, 1);
      tick();
      chk("bp_drained", bus.out_valid, 0);
    end

    // Reset after 2 of 4 words drops the partial group
    begin
      int g = 0;
      do_reset();
      for (int k = 1; k <= 2; k++) begin
        bus.in_valid = 1'b1; bus.in_data = k; bus.in_last = 1'b0;
        tick();
      end
      reset = 1'b1;
      bus.in_data = 77;
      tick();
      reset = 1'b0;
      idle();
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_in_ready", bus.in_ready, 1);
      for (int k = 21; k <= 24; k++) begin
        bus.in_valid = 1'b1; bus.in_data = k; bus.in_last = 1'b0;
        tick();
        chk("mid_rst_no_stale", bus.out_valid, 0);
      end
      idle();
      while (!bus.out_valid && g < 10) begin
        tick();
        g++;
      end
      chk("mid_rst_out_seen", bus.out_valid, 1);
      chk("mid_rst_out_data", bus.out_data, pk(21, 22, 23, 24));
      chk("mid_rst_out_count", bus.out_count, 4);
      chk("mid_rst_out_last", bus.out_last, 0);
    end

    // Random traffic against the grouping model
    begin
      int           sent = 0;
      int           cycles = 0;
      int           cur_n = 0;
      logic [W-1:0] cur = '0;
      bit           have = 0;
      logic [31:0]  pd = '0;
      bit           pl = 0;
      bit           in_acc, out_acc;
      orec_t        e, r;
      do_reset();
      while ((sent < 1000 || exp_q.size() != 0 || bus.out_valid) && cycles < 20000) begin
        if (!have && sent < 1000) begin
          pd   = $urandom;
          pl   = (sent == 999) || ($urandom_range(0, 4) == 0);
          have = 1;
        end
        bus.in_valid  = have && ($urandom_range(0, 1) == 1);
        bus.in_data   = bus.in_valid ? pd : $urandom;
        bus.in_last   = bus.in_valid ? pl : ($urandom_range(0, 1) == 1);
        bus.out_ready = (sent >= 1000) || ($urandom_range(0, 1) == 1);
        in_acc  = bus.in_valid && bus.in_ready;
        out_acc = bus.out_valid && bus.out_ready;
        if (out_acc) begin
          chk("rnd_expected_pending", (exp_q.size() > 0), 1);
          chk("rnd_count_nonzero", (bus.out_count != 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rnd_out_data",  bus.out_data,  e.d);
            chk("rnd_out_count", bus.out_count, e.c);
            chk("rnd_out_last",  bus.out_last,  e.l);
          end
        end
        if (in_acc) begin
          cur[cur_n*DATA +: DATA] = pd;
          cur_n++;
          if (cur_n == PACK || pl) begin
            r.d = cur; r.c = cur_n; r.l = pl;
            exp_q.push_back(r);
            cur = '0;
            cur_n = 0;
          end
          sent++;
          have = 0;
        end
        tick();
        cycles++;
      end
      idle();
      chk("rnd_words_sent", sent, 1000);
      chk("rnd_queue_empty", exp_q.size(), 0);
      chk("rnd_no_open_group", cur_n, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
